// File: rtl/alu_flag_stage.sv
// rtl/alu_flag_stage.sv - ALU result hold register (ADD) and processor status register P
// Closes the carry/decimal feedback loop back into the ALU.
module alu_flag_stage #(
    parameter logic [7:0] P_RESET   = 8'h24,
    parameter logic [7:0] ADD_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic [7:0] alu_out,
    input  logic       carry_out,
    input  logic       overflow,
    input  logic [7:0] db_in,
    input  logic       load_add,
    input  logic       c_from_alu,
    input  logic       v_from_alu,
    input  logic       nz_from_db,
    input  logic       bit_from_db,
    input  logic       p_from_db,
    input  logic [2:0] flag_op,
    input  logic [1:0] carry_sel,
    input  logic       dec_allow,
    input  logic       push_brk,
    output logic [7:0] add_q,
    output logic       carry_in,
    output logic       enable_dec,
    output logic [7:0] p_out,
    output logic       i_flag
);

    localparam logic [2:0] OP_CLC = 3'b001;
    localparam logic [2:0] OP_SEC = 3'b010;
    localparam logic [2:0] OP_CLI = 3'b011;
    localparam logic [2:0] OP_SEI = 3'b100;
    localparam logic [2:0] OP_CLD = 3'b101;
    localparam logic [2:0] OP_SED = 3'b110;
    localparam logic [2:0] OP_CLV = 3'b111;

    logic [7:0] add_r;
    logic       n_f, v_f, d_f, i_f, z_f, c_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            add_r <= ADD_RESET;
            n_f   <= P_RESET[7];
            v_f   <= P_RESET[6];
            d_f   <= P_RESET[3];
            i_f   <= P_RESET[2];
            z_f   <= P_RESET[1];
            c_f   <= P_RESET[0];
        end else if (rdy) begin
            if (load_add)
                add_r <= alu_out;

            if (p_from_db) begin
                n_f <= db_in[7];
                v_f <= db_in[6];
                d_f <= db_in[3];
                i_f <= db_in[2];
                z_f <= db_in[1];
                c_f <= db_in[0];
            end else begin
                // BIT and NZ both take N from db_in[7], so either strobe suffices
                if (bit_from_db || nz_from_db)
                    n_f <= db_in[7];
                if (nz_from_db)
                    z_f <= (db_in == 8'h00);

                if (flag_op == OP_CLV)
                    v_f <= 1'b0;
                else if (bit_from_db)
                    v_f <= db_in[6];
                else if (v_from_alu)
                    v_f <= overflow;

                if (flag_op == OP_CLC)
                    c_f <= 1'b0;
                else if (flag_op == OP_SEC)
                    c_f <= 1'b1;
                else if (c_from_alu)
                    c_f <= carry_out;

                if (flag_op == OP_CLI)
                    i_f <= 1'b0;
                else if (flag_op == OP_SEI)
                    i_f <= 1'b1;

                if (flag_op == OP_CLD)
                    d_f <= 1'b0;
                else if (flag_op == OP_SED)
                    d_f <= 1'b1;
            end
        end
    end

    always_comb begin
        carry_in = 1'b0;
        case (carry_sel)
            2'b00: carry_in = 1'b0;
            2'b01: carry_in = 1'b1;
            2'b10: carry_in = c_f;
            2'b11: carry_in = ~c_f;
            default: carry_in = 1'b0;
        endcase
    end

    assign enable_dec = d_f & dec_allow;
    assign add_q      = add_r;
    assign p_out      = {n_f, v_f, 1'b1, push_brk, d_f, i_f, z_f, c_f};
    assign i_flag     = i_f;

endmodule

// File: tb/tb_alu_flag_stage.sv
// tb/tb_alu_flag_stage.sv - directed vector table plus randomized run against a byte-level P model
module tb_alu_flag_stage;

    logic       clk = 1'b0;
    logic       rst, rdy;
    logic [7:0] alu_out, db_in;
    logic       carry_out, overflow;
    logic       load_add, c_from_alu, v_from_alu, nz_from_db, bit_from_db, p_from_db;
    logic [2:0] flag_op;
    logic [1:0] carry_sel;
    logic       dec_allow, push_brk;
    logic [7:0] add_q, p_out;
    logic       carry_in, enable_dec, i_flag;

    int n_vec = 0;
    int n_err = 0;

    alu_flag_stage dut (
        .clk(clk), .rst(rst), .rdy(rdy), .alu_out(alu_out), .carry_out(carry_out),
        .overflow(overflow), .db_in(db_in), .load_add(load_add), .c_from_alu(c_from_alu),
        .v_from_alu(v_from_alu), .nz_from_db(nz_from_db), .bit_from_db(bit_from_db),
        .p_from_db(p_from_db), .flag_op(flag_op), .carry_sel(carry_sel), .dec_allow(dec_allow),
        .push_brk(push_brk), .add_q(add_q), .carry_in(carry_in), .enable_dec(enable_dec),
        .p_out(p_out), .i_flag(i_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, rdy, ld, cfa, vfa, nz, bt, pdb;
        logic [2:0] fop;
        logic [1:0] csel;
        logic       dal, pb;
        logic [7:0] alu;
        logic       co, ov;
        logic [7:0] db;
        logic [7:0] e_add, e_p;
        logic       e_cin, e_edec, e_i;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; rdy = v.rdy; load_add = v.ld; c_from_alu = v.cfa; v_from_alu = v.vfa;
        nz_from_db = v.nz; bit_from_db = v.bt; p_from_db = v.pdb; flag_op = v.fop;
        carry_sel = v.csel; dec_allow = v.dal; push_brk = v.pb; alu_out = v.alu;
        carry_out = v.co; overflow = v.ov; db_in = v.db;
    endtask

    // Reference P held as a byte; sources applied lowest priority first so higher ones overwrite.
    logic [7:0] m_p, m_add;

    task automatic model_step();
        logic [7:0] np;
        if (rst) begin
            m_p = 8'h24; m_add = 8'h00;
        end else if (rdy) begin
            np = m_p;
            if (c_from_alu) np[0] = carry_out;
            if (v_from_alu) np[6] = overflow;
            if (nz_from_db) begin np[7] = db_in[7]; np[1] = (db_in == 8'h00); end
            if (bit_from_db) begin np[7] = db_in[7]; np[6] = db_in[6]; end
            case (flag_op)
                3'd1: np[0] = 1'b0;
                3'd2: np[0] = 1'b1;
                3'd3: np[2] = 1'b0;
                3'd4: np[2] = 1'b1;
                3'd5: np[3] = 1'b0;
                3'd6: np[3] = 1'b1;
                3'd7: np[6] = 1'b0;
                default: ;
            endcase
            if (p_from_db) np = (db_in & 8'hCF) | 8'h20;
            m_p = np;
            if (load_add) m_add = alu_out;
        end
    endtask

    initial begin
        logic [7:0] e_p;
        logic       e_cin;
        vec_t       v;

        //          rst rdy ld cfa vfa nz bt pdb fop csel dal pb alu  co ov db     add   p    cin ed i
        vecs[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h24, 0, 0, 1};
        vecs[1]  = '{1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 1, 8'h00, 0, 0, 8'h00, 8'h00, 8'h34, 0, 0, 1};
        vecs[2]  = '{0, 1, 0, 0, 0, 0, 0, 0, 3'd2, 2'd2, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h25, 1, 0, 1};
        vecs[3]  = '{0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 2'd3, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h25, 0, 0, 1};
        vecs[4]  = '{0, 1, 0, 0, 0, 0, 0, 0, 3'd1, 2'd2, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h24, 0, 0, 1};
        vecs[5]  = '{0, 1, 1, 1, 1, 1, 0, 0, 3'd0, 2'd2, 0, 0, 8'h80, 1, 1, 8'h80, 8'h80, 8'hE5, 1, 0, 1};
        vecs[6]  = '{0, 1, 0, 0, 0, 0, 0, 1, 3'd1, 2'd2, 0, 0, 8'h00, 0, 0, 8'hFF, 8'h80, 8'hEF, 1, 0, 1};
        vecs[7]  = '{0, 1, 0, 0, 0, 0, 0, 0, 3'd5, 2'd2, 1, 0, 8'h00, 0, 0, 8'h00, 8'h80, 8'hE7, 1, 0, 1};
        vecs[8]  = '{0, 1, 0, 0, 0, 0, 0, 0, 3'd6, 2'd2, 1, 0, 8'h00, 0, 0, 8'h00, 8'h80, 8'hEF, 1, 1, 1};
        vecs[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0, 8'h00, 0, 0, 8'h00, 8'h80, 8'hEF, 1, 0, 1};
        vecs[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 3'd1, 2'd2, 0, 0, 8'h55, 0, 0, 8'h00, 8'h80, 8'hEF, 1, 0, 1};
        vecs[11] = '{0, 1, 1, 0, 0, 0, 0, 0, 3'd1, 2'd2, 0, 0, 8'h55, 0, 0, 8'h00, 8'h55, 8'hEE, 0, 0, 1};
        vecs[12] = '{1, 0, 1, 0, 0, 0, 0, 1, 3'd2, 2'd2, 0, 0, 8'hAA, 0, 0, 8'h00, 8'h00, 8'h24, 0, 0, 1};
        vecs[13] = '{0, 1, 0, 0, 0, 1, 1, 0, 3'd0, 2'd2, 0, 0, 8'h00, 0, 0, 8'h40, 8'h00, 8'h64, 0, 0, 1};
        vecs[14] = '{0, 1, 0, 0, 1, 1, 0, 0, 3'd7, 2'd2, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 8'h26, 0, 0, 1};
        vecs[15] = '{0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 2'd1, 0, 0, 8'h00, 1, 1, 8'h00, 8'h00, 8'h26, 1, 0, 1};
        vecs[16] = '{0, 1, 0, 0, 0, 0, 0, 0, 3'd3, 2'd3, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h22, 1, 0, 0};

        for (int k = 0; k < 17; k++) begin
            drive(vecs[k]);
            @(posedge clk);
            #1;
            chk("add_q", k, add_q, vecs[k].e_add);
            chk("p_out", k, p_out, vecs[k].e_p);
            chk("carry_in", k, {7'd0, carry_in}, {7'd0, vecs[k].e_cin});
            chk("enable_dec", k, {7'd0, enable_dec}, {7'd0, vecs[k].e_edec});
            chk("i_flag", k, {7'd0, i_flag}, {7'd0, vecs[k].e_i});
        end

        // Stall held for several cycles, then released: one-cycle latency on both registers
        v = vecs[0]; v.rst = 0; v.rdy = 0; v.ld = 1; v.alu = 8'h3C; v.fop = 3'd2; v.csel = 2'd2;
        drive(v);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("stall_add", k, add_q, 8'h00);
            chk("stall_p", k, p_out, 8'h22);
            chk("stall_cin", k, {7'd0, carry_in}, 8'h00);
        end
        rdy = 1'b1;
        @(posedge clk); #1;
        chk("release_add", 0, add_q, 8'h3C);
        chk("release_p", 0, p_out, 8'h23);
        chk("release_cin", 0, {7'd0, carry_in}, 8'h01);

        rst = 1'b1;
        model_step();
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            rst        = ($urandom_range(0, 31) == 0);
            rdy        = ($urandom_range(0, 3) != 0);
            alu_out    = 8'($urandom);
            db_in      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            carry_out  = 1'($urandom);
            overflow   = 1'($urandom);
            load_add   = 1'($urandom);
            c_from_alu = 1'($urandom);
            v_from_alu = 1'($urandom);
            nz_from_db = 1'($urandom);
            bit_from_db = ($urandom_range(0, 3) == 0);
            p_from_db  = ($urandom_range(0, 5) == 0);
            flag_op    = 3'($urandom);
            carry_sel  = 2'($urandom);
            dec_allow  = 1'($urandom);
            push_brk   = 1'($urandom);
            #1;
            e_p = {m_p[7:5], push_brk, m_p[3:0]};
            case (carry_sel)
                2'd0: e_cin = 1'b0;
                2'd1: e_cin = 1'b1;
                2'd2: e_cin = m_p[0];
                default: e_cin = ~m_p[0];
            endcase
            chk("rnd_add_q", k, add_q, m_add);
            chk("rnd_p_out", k, p_out, e_p);
            chk("rnd_carry_in", k, {7'd0, carry_in}, {7'd0, e_cin});
            chk("rnd_enable_dec", k, {7'd0, enable_dec}, {7'd0, m_p[3] & dec_allow});
            chk("rnd_i_flag", k, {7'd0, i_flag}, {7'd0, m_p[2]});
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
